// File: rtl/bram_tdp_be.sv
// bram_tdp_be: single-clock true dual-port block RAM with per-byte write
// enables, selectable write mode (READ_FIRST / WRITE_FIRST / NO_CHANGE),
// OUT_STAGES extra output registers with read-valid tracking, and a
// one-cycle collision pulse for same-address accesses involving a write.
// Optional: define BRAM_TDP_PARITY_EN to store one even-parity bit per byte
// and report per-lane parity errors on read; otherwise *_perr are tied to 0.
module bram_tdp_be #(
  parameter int    DATA_WIDTH = 32,
  parameter int    BYTE_WIDTH = 8,
  parameter int    DEPTH      = 1024,
  parameter string WRITE_MODE = "READ_FIRST",
  parameter int    OUT_STAGES = 1,
  parameter string INIT_FILE  = "",
  localparam int   NB         = DATA_WIDTH / BYTE_WIDTH,
  localparam int   ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clka,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic [NB-1:0]         wea,
  input  logic [ADDR_W-1:0]     addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  douta_vld,
  input  logic                  enb,
  input  logic [NB-1:0]         web,
  input  logic [ADDR_W-1:0]     addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  doutb_vld,
  output logic                  collision,
  output logic [NB-1:0]         douta_perr,
  output logic [NB-1:0]         doutb_perr
);

  localparam bit IS_WF = (WRITE_MODE == "WRITE_FIRST");
  localparam bit IS_NC = (WRITE_MODE == "NO_CHANGE");

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
`ifdef BRAM_TDP_PARITY_EN
  logic [NB-1:0]         par_reg [DEPTH];
`endif

  // Even parity per byte lane: the stored bit makes each lane+bit even.
  function automatic logic [NB-1:0] lane_par(input logic [DATA_WIDTH-1:0] w);
    logic [NB-1:0] p;
    p = '0;
    for (int k = 0; k < NB; k++) p[k] = ^w[k*BYTE_WIDTH +: BYTE_WIDTH];
    return p;
  endfunction

  // Power-up memory image: zeros.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_reg[i] = '0;
`ifdef BRAM_TDP_PARITY_EN
    for (int i = 0; i < DEPTH; i++) par_reg[i] = lane_par(mem_reg[i]);
`endif
  end

  // Port decode: an operation needs enable and no reset in the same cycle.
  logic op_a, op_b, wr_a, wr_b, rd_a, rd_b, inr_a, inr_b, same_addr, coll;
  assign op_a      = ena & ~rstb;
  assign op_b      = enb & ~rstb;
  assign wr_a      = op_a & (|wea);
  assign wr_b      = op_b & (|web);
  assign rd_a      = op_a & (IS_NC ? ~(|wea) : 1'b1);
  assign rd_b      = op_b & (IS_NC ? ~(|web) : 1'b1);
  assign inr_a     = (32'(addra) < DEPTH);
  assign inr_b     = (32'(addrb) < DEPTH);
  assign same_addr = op_a & op_b & inr_a & inr_b & (addra == addrb);
  assign coll      = same_addr & (wr_a | wr_b);

  // Pre-write words; out-of-range addresses read as zero and never wrap.
  logic [DATA_WIDTH-1:0] old_a, old_b, merged_a, merged_b, rd_data_a, rd_data_b;
  logic [NB-1:0]         lane_wa, lane_wb;
  assign old_a = inr_a ? mem_reg[addra] : '0;
  assign old_b = inr_b ? mem_reg[addrb] : '0;

`ifdef BRAM_TDP_PARITY_EN
  logic [NB-1:0] par_old_a, par_old_b, perr_a0, perr_b0;
  assign par_old_a = inr_a ? par_reg[addra] : '0;
  assign par_old_b = inr_b ? par_reg[addrb] : '0;
`endif

  // Per-lane write qualifiers and post-write views; on a shared address the
  // merged word is the same for both ports, with port A winning shared lanes.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    localparam int LO = gi * BYTE_WIDTH;
    assign lane_wa[gi] = wr_a & inr_a & wea[gi];
    assign lane_wb[gi] = wr_b & inr_b & web[gi];
    assign merged_a[LO +: BYTE_WIDTH] =
      lane_wa[gi]               ? dina[LO +: BYTE_WIDTH] :
      (same_addr & lane_wb[gi]) ? dinb[LO +: BYTE_WIDTH] : old_a[LO +: BYTE_WIDTH];
    assign merged_b[LO +: BYTE_WIDTH] =
      (same_addr & lane_wa[gi]) ? dina[LO +: BYTE_WIDTH] :
      lane_wb[gi]               ? dinb[LO +: BYTE_WIDTH] : old_b[LO +: BYTE_WIDTH];
`ifdef BRAM_TDP_PARITY_EN
    // Freshly written lanes carry fresh parity, so only old lanes can mismatch.
    logic new_a, new_b;
    assign new_a = IS_WF & (lane_wa[gi] | (same_addr & lane_wb[gi]));
    assign new_b = IS_WF & (lane_wb[gi] | (same_addr & lane_wa[gi]));
    assign perr_a0[gi] = inr_a & ~new_a & ((^old_a[LO +: BYTE_WIDTH]) ^ par_old_a[gi]);
    assign perr_b0[gi] = inr_b & ~new_b & ((^old_b[LO +: BYTE_WIDTH]) ^ par_old_b[gi]);
`endif
  end

  assign rd_data_a = IS_WF ? merged_a : old_a;
  assign rd_data_b = IS_WF ? merged_b : old_b;

  // Memory write: B lanes first, then A lanes, so A wins shared lanes.
  always_ff @(posedge clka) begin
    for (int k = 0; k < NB; k++) begin
      if (lane_wb[k]) begin
        mem_reg[addrb][k*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[k*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef BRAM_TDP_PARITY_EN
        par_reg[addrb][k] <= ^dinb[k*BYTE_WIDTH +: BYTE_WIDTH];
`endif
      end
      if (lane_wa[k]) begin
        mem_reg[addra][k*BYTE_WIDTH +: BYTE_WIDTH] <= dina[k*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef BRAM_TDP_PARITY_EN
        par_reg[addra][k] <= ^dina[k*BYTE_WIDTH +: BYTE_WIDTH];
`endif
      end
    end
  end

  logic [OUT_STAGES:0]   va_reg, vb_reg;
  logic [DATA_WIDTH-1:0] da_reg [OUT_STAGES+1];
  logic [DATA_WIDTH-1:0] db_reg [OUT_STAGES+1];
  logic                  col_reg;

  // Read pipeline: valid shifts every cycle, data stages load only behind a
  // valid; reset flushes everything so in-flight reads never emerge.
  always_ff @(posedge clka) begin
    if (rstb) begin
      va_reg  <= '0;
      vb_reg  <= '0;
      col_reg <= 1'b0;
      for (int i = 0; i <= OUT_STAGES; i++) begin
        da_reg[i] <= '0;
        db_reg[i] <= '0;
      end
    end else begin
      va_reg[0] <= rd_a;
      vb_reg[0] <= rd_b;
      col_reg   <= coll;
      if (rd_a) da_reg[0] <= rd_data_a;
      if (rd_b) db_reg[0] <= rd_data_b;
      for (int i = 1; i <= OUT_STAGES; i++) begin
        va_reg[i] <= va_reg[i-1];
        vb_reg[i] <= vb_reg[i-1];
        if (va_reg[i-1]) da_reg[i] <= da_reg[i-1];
        if (vb_reg[i-1]) db_reg[i] <= db_reg[i-1];
      end
    end
  end

  assign douta     = da_reg[OUT_STAGES];
  assign doutb     = db_reg[OUT_STAGES];
  assign douta_vld = va_reg[OUT_STAGES];
  assign doutb_vld = vb_reg[OUT_STAGES];
  assign collision = col_reg;

`ifdef BRAM_TDP_PARITY_EN
  logic [NB-1:0] pa_reg [OUT_STAGES+1];
  logic [NB-1:0] pb_reg [OUT_STAGES+1];

  // Parity-error pipeline travels alongside the data stages.
  always_ff @(posedge clka) begin
    if (rstb) begin
      for (int i = 0; i <= OUT_STAGES; i++) begin
        pa_reg[i] <= '0;
        pb_reg[i] <= '0;
      end
    end else begin
      if (rd_a) pa_reg[0] <= perr_a0;
      if (rd_b) pb_reg[0] <= perr_b0;
      for (int i = 1; i <= OUT_STAGES; i++) begin
        if (va_reg[i-1]) pa_reg[i] <= pa_reg[i-1];
        if (vb_reg[i-1]) pb_reg[i] <= pb_reg[i-1];
      end
    end
  end

  assign douta_perr = pa_reg[OUT_STAGES] & {NB{va_reg[OUT_STAGES]}};
  assign doutb_perr = pb_reg[OUT_STAGES] & {NB{vb_reg[OUT_STAGES]}};
`else
  assign douta_perr = '0;
  assign doutb_perr = '0;
`endif

endmodule

// File: tb/tb_bram_tdp_be.sv
// Testbench for bram_tdp_be: three instances (READ_FIRST L=2, WRITE_FIRST
// L=1, NO_CHANGE L=3), DEPTH=12, directed vectors with hand-computed results
// pushed into a scoreboard; a negedge monitor pops and compares every output.
module tb_bram_tdp_be;
  localparam int AW = 4;

  logic clka = 1'b0;
  logic rstb = 1'b1;
  logic [2:0] ena_d = '0, enb_d = '0;
  logic [3:0] wea = '0, web = '0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [31:0] dina = '0, dinb = '0;

  logic [31:0] douta_w [3];
  logic [31:0] doutb_w [3];
  logic [2:0]  douta_vld_w, doutb_vld_w, coll_w;
  logic [3:0]  douta_perr_w [3];
  logic [3:0]  doutb_perr_w [3];

  int cyc = 0;
  int last_e = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    int          cyc;
    logic [31:0] data;
    logic [3:0]  perr;
  } exp_t;
  exp_t sb_q[$];

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  bram_tdp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(12), .WRITE_MODE("READ_FIRST"),
                .OUT_STAGES(1), .INIT_FILE("")) dut_rf (
    .clka(clka), .rstb(rstb),
    .ena(ena_d[0]), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta_w[0]), .douta_vld(douta_vld_w[0]),
    .enb(enb_d[0]), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(doutb_w[0]), .doutb_vld(doutb_vld_w[0]),
    .collision(coll_w[0]), .douta_perr(douta_perr_w[0]), .doutb_perr(doutb_perr_w[0]));

  bram_tdp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(12), .WRITE_MODE("WRITE_FIRST"),
                .OUT_STAGES(0), .INIT_FILE("")) dut_wf (
    .clka(clka), .rstb(rstb),
    .ena(ena_d[1]), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta_w[1]), .douta_vld(douta_vld_w[1]),
    .enb(enb_d[1]), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(doutb_w[1]), .doutb_vld(doutb_vld_w[1]),
    .collision(coll_w[1]), .douta_perr(douta_perr_w[1]), .doutb_perr(doutb_perr_w[1]));

  bram_tdp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(12), .WRITE_MODE("NO_CHANGE"),
                .OUT_STAGES(2), .INIT_FILE("")) dut_nc (
    .clka(clka), .rstb(rstb),
    .ena(ena_d[2]), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta_w[2]), .douta_vld(douta_vld_w[2]),
    .enb(enb_d[2]), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(doutb_w[2]), .doutb_vld(doutb_vld_w[2]),
    .collision(coll_w[2]), .douta_perr(douta_perr_w[2]), .doutb_perr(doutb_perr_w[2]));

  // Read latency per instance index.
  function automatic int lat_of(input int d);
    if (d == 0) return 2;
    if (d == 1) return 1;
    return 3;
  endfunction

  // id = instance*3 + {0: port A, 1: port B, 2: collision}
  task automatic push_exp(input int id, input logic [31:0] data, input logic [3:0] perr = 4'b0);
    exp_t e;
    int lat;
    lat = ((id % 3) == 2) ? 1 : lat_of(id / 3);
    e.id = id;
    e.cyc = last_e + lat - 1;
    e.data = data;
    e.perr = perr;
    sb_q.push_back(e);
  endtask

  // One clock edge of stimulus on instance d.
  task automatic op(input int d,
                    input logic ae, input logic [3:0] aw, input int aa, input logic [31:0] ad,
                    input logic be, input logic [3:0] bw, input int ba, input logic [31:0] bd);
    ena_d = '0;
    enb_d = '0;
    ena_d[d] = ae;
    enb_d[d] = be;
    wea = aw; addra = AW'(aa); dina = ad;
    web = bw; addrb = AW'(ba); dinb = bd;
    @(posedge clka);
    #1;
    last_e = cyc;
    ena_d = '0;
    enb_d = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end else begin
      $display("ok %s: %h", name, got);
    end
  endtask

  task automatic mon(input int id, input logic vld, input logic [31:0] data, input logic [3:0] perr);
    int idx;
    idx = -1;
    if (!vld) begin
      if (perr != 4'b0) begin
        checks++;
        errors++;
        $display("FAIL perr_idle id=%0d: got %b expected 0000", id, perr);
      end
      return;
    end
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].id == id) begin
        idx = i;
        break;
      end
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected_out id=%0d cyc=%0d: got data %h expected no output", id, cyc, data);
      return;
    end
    if (sb_q[idx].cyc != cyc || data !== sb_q[idx].data || perr !== sb_q[idx].perr) begin
      errors++;
      $display("FAIL out id=%0d: got cyc=%0d data=%h perr=%b expected cyc=%0d data=%h perr=%b",
               id, cyc, data, perr, sb_q[idx].cyc, sb_q[idx].data, sb_q[idx].perr);
    end else begin
      $display("ok out id=%0d cyc=%0d data=%h perr=%b", id, cyc, data, perr);
    end
    sb_q.delete(idx);
  endtask

  // Monitor: sample away from the active edge and retire scoreboard entries.
  always @(negedge clka) begin
    for (int d = 0; d < 3; d++) begin
      mon(d*3 + 0, douta_vld_w[d], douta_w[d], douta_perr_w[d]);
      mon(d*3 + 1, doutb_vld_w[d], doutb_w[d], doutb_perr_w[d]);
      mon(d*3 + 2, coll_w[d], 32'(coll_w[d]), 4'b0);
    end
  end

  initial begin
    // Reset state
    idle(3);
    rstb = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_douta%0d", d), douta_w[d], 32'h0);
      chk($sformatf("rst_doutb%0d", d), doutb_w[d], 32'h0);
      chk($sformatf("rst_vld%0d", d), {30'b0, douta_vld_w[d], doutb_vld_w[d]}, 32'h0);
      chk($sformatf("rst_coll%0d", d), {31'b0, coll_w[d]}, 32'h0);
    end

    // READ_FIRST, L=2
    op(0, 1, 4'hF, 5, 32'hDEADBEEF, 0, 4'h0, 0, 32'h0); push_exp(0, 32'h0);
    op(0, 0, 4'h0, 0, 32'h0,        1, 4'h0, 5, 32'h0); push_exp(1, 32'hDEADBEEF);
    op(0, 1, 4'hF, 3, 32'h11223344, 0, 4'h0, 0, 32'h0); push_exp(0, 32'h0);
    op(0, 1, 4'h5, 3, 32'hAABBCCDD, 0, 4'h0, 0, 32'h0); push_exp(0, 32'h11223344);
    op(0, 0, 4'h0, 0, 32'h0,        1, 4'h0, 3, 32'h0); push_exp(1, 32'h11BB33DD);
    op(0, 1, 4'h0, 5, 32'h0,        0, 4'h0, 0, 32'h0); push_exp(0, 32'hDEADBEEF);
    op(0, 1, 4'h0, 3, 32'h0,        0, 4'h0, 0, 32'h0); push_exp(0, 32'h11BB33DD);
    // collision: both write addr 4, A wins lane 0, read data is the old word
    op(0, 1, 4'h1, 4, 32'h000000AA, 1, 4'h3, 4, 32'h0000BB00);
    push_exp(0, 32'h0); push_exp(1, 32'h0); push_exp(2, 32'h1);
    // two reads of the same address: no collision
    op(0, 1, 4'h0, 4, 32'h0, 1, 4'h0, 4, 32'h0);
    push_exp(0, 32'h0000BBAA); push_exp(1, 32'h0000BBAA);
    // out of range: write ignored, read returns 0 with valid, no collision, no wrap
    op(0, 1, 4'hF, 13, 32'hFFFFFFFF, 1, 4'h0, 13, 32'h0); push_exp(0, 32'h0); push_exp(1, 32'h0);
    op(0, 1, 4'h0, 13, 32'h0, 1, 4'h0, 1, 32'h0);         push_exp(0, 32'h0); push_exp(1, 32'h0);
    // last valid address
    op(0, 1, 4'hF, 11, 32'hCAFEF00D, 0, 4'h0, 0, 32'h0); push_exp(0, 32'h0);
    op(0, 0, 4'h0, 0, 32'h0, 1, 4'h0, 11, 32'h0);         push_exp(1, 32'hCAFEF00D);

    // WRITE_FIRST, L=1
    op(1, 1, 4'h1, 7, 32'h000000AA, 1, 4'h3, 7, 32'h0000BB00);
    push_exp(3, 32'h0000BBAA); push_exp(4, 32'h0000BBAA); push_exp(5, 32'h1);
    op(1, 1, 4'h0, 7, 32'h0, 0, 4'h0, 0, 32'h0);          push_exp(3, 32'h0000BBAA);
    op(1, 1, 4'hC, 8, 32'h12345678, 0, 4'h0, 0, 32'h0);   push_exp(3, 32'h12340000);
    op(1, 0, 4'h0, 0, 32'h0, 1, 4'h0, 8, 32'h0);          push_exp(4, 32'h12340000);
    op(1, 1, 4'hF, 9, 32'h01020304, 1, 4'hF, 10, 32'h0A0B0C0D);
    push_exp(3, 32'h01020304); push_exp(4, 32'h0A0B0C0D);

    // NO_CHANGE, L=3
    op(2, 1, 4'hF, 0, 32'h5, 0, 4'h0, 0, 32'h0);
    op(2, 1, 4'h0, 0, 32'h0, 0, 4'h0, 0, 32'h0);          push_exp(6, 32'h5);
    op(2, 1, 4'hF, 0, 32'h9, 0, 4'h0, 0, 32'h0);
    idle(5);
    chk("nc_hold_douta", douta_w[2], 32'h5);
    op(2, 1, 4'h0, 0, 32'h0, 0, 4'h0, 0, 32'h0);          push_exp(6, 32'h9);
    op(2, 1, 4'h1, 1, 32'h77, 1, 4'h1, 1, 32'h66);        push_exp(8, 32'h1);
    op(2, 0, 4'h0, 0, 32'h0, 1, 4'h0, 1, 32'h0);          push_exp(7, 32'h77);
    idle(5);

    // Reset mid-stream: read on cycle 0, reset with a read on cycle 1
    op(0, 1, 4'h0, 5, 32'h0, 1, 4'h0, 3, 32'h0);
    rstb = 1'b1;
    op(0, 1, 4'h0, 5, 32'h0, 1, 4'h0, 3, 32'h0);
    rstb = 1'b0;
    chk("midrst_douta", douta_w[0], 32'h0);
    chk("midrst_doutb", doutb_w[0], 32'h0);
    idle(4);
    op(0, 1, 4'h0, 5, 32'h0, 1, 4'h0, 3, 32'h0);
    push_exp(0, 32'hDEADBEEF); push_exp(1, 32'h11BB33DD);

`ifdef BRAM_TDP_PARITY_EN
    // Parity: corrupt lane 0 of a stored word behind the RAM's back
    op(0, 1, 4'hF, 2, 32'h000000FF, 0, 4'h0, 0, 32'h0); push_exp(0, 32'h0);
    idle(1);
    dut_rf.mem_reg[2] = dut_rf.mem_reg[2] ^ 32'h1;
    op(0, 1, 4'h0, 2, 32'h0, 0, 4'h0, 0, 32'h0);        push_exp(0, 32'h000000FE, 4'b0001);
`else
    op(0, 1, 4'hF, 2, 32'h000000FF, 0, 4'h0, 0, 32'h0); push_exp(0, 32'h0);
    op(0, 1, 4'h0, 2, 32'h0, 0, 4'h0, 0, 32'h0);        push_exp(0, 32'h000000FF);
`endif

    idle(8);
    while (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing_out id=%0d: got no output expected data %h at cyc %0d",
               sb_q[0].id, sb_q[0].data, sb_q[0].cyc);
      sb_q.delete(0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
